// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle logic/arith/shift ops; MUL is iterative shift-add over WIDTH cycles.
module multicycle_alu #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [2:0]       select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               live_q, live_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic [2*WIDTH-1:0] acc_next;

    // Single-cycle datapath; shifts by WIDTH or more naturally give zero
    always_comb begin
        add_full  = {1'b0, input1} + {1'b0, input2};
        sub_full  = {1'b0, input1} - {1'b0, input2};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        unique case (select)
            OP_ADD: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                            (add_full[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_AND: alu_res = input1 & input2;
            OP_OR:  alu_res = input1 | input2;
            OP_XOR: alu_res = input1 ^ input2;
            OP_SUB: begin
                alu_res   = sub_full[WIDTH-1:0];
                alu_carry = sub_full[WIDTH];
                alu_ovf   = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SHL: alu_res = input1 << input2;
            OP_SHR: alu_res = input1 >> input2;
            OP_MUL: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        live_d    = 1'b1;
        result_d  = result_q;
        flags_d   = flags_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // live_q holds off acceptance until the first edge after reset
                in_ready = live_q;
                if (in_valid && live_q) begin
                    if (select == OP_MUL) begin
                        state_d  = MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, input1};
                        mplier_d = input2;
                        cnt_d    = '0;
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        flags_d  = {alu_carry, alu_ovf, (alu_res == '0)};
                    end
                end
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = acc_next[WIDTH-1:0];
                    flags_d  = {(|acc_next[2*WIDTH-1:WIDTH]), 1'b0,
                                (acc_next[WIDTH-1:0] == '0)};
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            live_q   <= live_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule
